// File: rtl/serial_rx_sequencer.sv
// Master-side sequencer for the sensor link's 8-bit serial-to-parallel shift register:
// drives cs_n/sclk, pulses shift_en once per bit and hands each captured byte out on valid/ready.
module serial_rx_sequencer #(
    parameter int CLK_DIV     = 4,
    parameter int FRAME_BYTES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       shift_en,
    input  logic [7:0] par_in,
    output logic       sclk,
    output logic       cs_n,
    output logic       busy,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       byte_last,
    output logic       frame_done
);
    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [4:0] LAST_BYTE = 5'(FRAME_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT_LO, S_SHIFT_HI, S_CAPTURE, S_END
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_div;
    logic [3:0] r_bits;
    logic [4:0] r_byte_idx;
    logic [7:0] r_byte_data;
    logic       r_byte_valid;
    logic       r_byte_last;
    logic       w_div_done;
    logic       w_timed;
    logic       w_abort;
    logic       w_load;
    logic       w_bit_done;

    assign w_div_done = (r_div == DIV_LAST);
    assign w_timed    = (r_state == S_SETUP) || (r_state == S_SHIFT_LO) || (r_state == S_SHIFT_HI);
    assign w_abort    = abort && (r_state != S_IDLE);

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_bit_done   = 1'b0;
        case (r_state)
            S_IDLE:     if (start && !abort) w_state_next = S_SETUP;
            S_SETUP:    if (w_div_done) w_state_next = S_SHIFT_LO;
            S_SHIFT_LO: if (w_div_done) w_state_next = S_SHIFT_HI;
            S_SHIFT_HI: begin
                if (w_div_done) begin
                    w_bit_done   = 1'b1;
                    w_state_next = (r_bits == 4'd7) ? S_CAPTURE : S_SHIFT_LO;
                end
            end
            S_CAPTURE: begin
                // A pending byte may be drained and replaced in the same cycle.
                if (!r_byte_valid || byte_ready) begin
                    w_load       = 1'b1;
                    w_state_next = (r_byte_idx == LAST_BYTE) ? S_END : S_SHIFT_LO;
                end
            end
            S_END:      w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_state_next = S_IDLE;
            w_load       = 1'b0;
            w_bit_done   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_div      <= 8'd0;
            r_bits     <= 4'd0;
            r_byte_idx <= 5'd0;
        end else begin
            r_state <= w_state_next;
            if (!w_timed || (w_state_next != r_state))
                r_div <= 8'd0;
            else
                r_div <= r_div + 8'd1;
            if ((r_state == S_IDLE) || w_load)
                r_bits <= 4'd0;
            else if (w_bit_done)
                r_bits <= r_bits + 4'd1;
            if (r_state == S_IDLE)
                r_byte_idx <= 5'd0;
            else if (w_load)
                r_byte_idx <= r_byte_idx + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_byte_data  <= 8'h00;
            r_byte_valid <= 1'b0;
            r_byte_last  <= 1'b0;
        end else if (w_abort) begin
            r_byte_valid <= 1'b0;
            r_byte_last  <= 1'b0;
        end else if (w_load) begin
            r_byte_data  <= par_in;
            r_byte_valid <= 1'b1;
            r_byte_last  <= (r_byte_idx == LAST_BYTE);
        end else if (byte_ready) begin
            r_byte_valid <= 1'b0;
        end
    end

    // The external register shifts on the first clk of each high half-period.
    assign shift_en   = (r_state == S_SHIFT_HI) && (r_div == 8'd0);
    assign sclk       = (r_state == S_SHIFT_HI);
    assign cs_n       = (r_state == S_IDLE) || (r_state == S_END);
    assign busy       = (r_state != S_IDLE);
    assign frame_done = (r_state == S_END);
    assign byte_data  = r_byte_data;
    assign byte_valid = r_byte_valid;
    assign byte_last  = r_byte_last;

endmodule

// File: tb/tb_serial_rx_sequencer.sv
// Bench for serial_rx_sequencer: two configurations (CLK_DIV=2/FRAME_BYTES=2 and 1/1) share stimulus
// and are each checked every cycle against a timeline model, plus directed literal checks.
module tb_serial_rx_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, abort, byte_ready, directed;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int inst, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t got %0h expected %0h", name, inst, $time, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL timeout %s t=%0t got no event expected event", name, $time);
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g
        localparam int D  = (gi == 0) ? 2 : 1;
        localparam int FB = (gi == 0) ? 2 : 1;

        logic       shift_en, sclk, cs_n, busy, byte_valid, byte_last, frame_done;
        logic [7:0] par_in, byte_data;
        logic       din;
        logic [7:0] sr;
        logic [7:0] pat [0:1];

        serial_rx_sequencer #(.CLK_DIV(D), .FRAME_BYTES(FB)) dut (
            .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
            .shift_en(shift_en), .par_in(par_in), .sclk(sclk), .cs_n(cs_n),
            .busy(busy), .byte_data(byte_data), .byte_valid(byte_valid),
            .byte_ready(byte_ready), .byte_last(byte_last), .frame_done(frame_done)
        );

        initial begin
            sr     = 8'h00;
            pat[0] = 8'hA5;
            pat[1] = 8'h3C;
        end

        // External shift register: serial bit enters at the top, so the first bit lands in bit 0.
        assign par_in = sr;
        always @(posedge clk) if (shift_en) sr <= {din, sr[7:1]};

        // Model: position inside the frame is elapsed cycles since the current byte segment began.
        bit         m_active, m_end, m_first, m_valid, m_last;
        int         m_seg, m_byte;
        logic [7:0] m_sr = 8'h00;
        logic [7:0] m_data = 8'h00;
        bit         e_cs_n = 1'b1, e_sclk, e_sh, e_cap;
        int         e_bit;
        bit         armed = 1'b0;

        always @(posedge clk) begin
            bit load;
            int e;
            if (e_sh) m_sr = {din, m_sr[7:1]};
            if (!rst_n) begin
                m_active = 0; m_end = 0; m_valid = 0; m_last = 0; m_data = 8'h00;
            end else begin
                load = e_cap && (!m_valid || byte_ready);
                if (m_valid && byte_ready) m_valid = 0;
                if (m_active && abort) begin
                    m_active = 0; m_end = 0; m_valid = 0; m_last = 0;
                end else if (!m_active) begin
                    if (start && !abort) begin
                        m_active = 1; m_end = 0; m_first = 1; m_byte = 0; m_seg = cyc + 1;
                    end
                end else if (m_end) begin
                    m_active = 0;
                end else if (load) begin
                    m_valid = 1;
                    m_data  = m_sr;
                    m_last  = (m_byte == FB - 1);
                    if (m_last) m_end = 1;
                    else begin
                        m_byte++; m_first = 0; m_seg = cyc + 1;
                    end
                end
            end
            e_cs_n = 1; e_sclk = 0; e_sh = 0; e_cap = 0; e_bit = 0;
            if (m_active && !m_end) begin
                e_cs_n = 0;
                e = cyc + 1 - m_seg - (m_first ? D : 0);
                if (e >= 0 && e < 16 * D) begin
                    e_sclk = (e % (2 * D)) >= D;
                    e_sh   = (e % (2 * D)) == D;
                    e_bit  = e / (2 * D);
                end else if (e >= 16 * D) begin
                    e_cap = 1;
                end
            end
            din <= (directed && e_sh) ? pat[m_byte & 1][e_bit] : 1'($urandom_range(0, 1));
            armed = 1;
        end

        always @(negedge clk) begin
            if (armed) begin
                check("cs_n", gi, cs_n, e_cs_n);
                check("sclk", gi, sclk, e_sclk);
                check("shift_en", gi, shift_en, e_sh);
                check("busy", gi, busy, m_active);
                check("frame_done", gi, frame_done, m_active && m_end);
                check("byte_valid", gi, byte_valid, m_valid);
                check("byte_last", gi, byte_last, m_last);
                check("byte_data", gi, byte_data, m_data);
            end
        end

        int         pulses = 0, fdone = 0, nbytes = 0;
        logic [7:0] got_b [0:63];
        logic       got_l [0:63];
        always @(posedge clk) begin
            if (shift_en) pulses <= pulses + 1;
            if (frame_done) fdone <= fdone + 1;
            if (rst_n && byte_valid && byte_ready) begin
                got_b[nbytes % 64] <= byte_data;
                got_l[nbytes % 64] <= byte_last;
                nbytes <= nbytes + 1;
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while ((g[0].busy || g[1].busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) timeout(name);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t got no finish expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, p1, f0, f1, b0, b1, n;
        rst_n = 0; start = 0; abort = 0; byte_ready = 1; directed = 1;
        repeat (3) @(negedge clk);
        check("rst_cs_n", 0, g[0].cs_n, 1);
        check("rst_busy", 0, g[0].busy, 0);
        check("rst_data", 0, g[0].byte_data, 8'h00);
        check("rst_valid", 1, g[1].byte_valid, 0);
        rst_n = 1;
        @(negedge clk);

        // Frame with ready high: 0xA5 then 0x3C on inst0, 0xA5 alone on inst1.
        p0 = g[0].pulses; p1 = g[1].pulses; f0 = g[0].fdone; f1 = g[1].fdone;
        b0 = g[0].nbytes; b1 = g[1].nbytes;
        start = 1;
        @(negedge clk); start = 0;
        check("setup_cs_n", 0, g[0].cs_n, 0);
        check("setup_cs_n", 1, g[1].cs_n, 0);
        @(negedge clk);
        @(negedge clk);
        check("div1_sclk_hi", 1, g[1].sclk, 1);
        check("div1_shift", 1, g[1].shift_en, 1);
        @(negedge clk);
        check("div1_sclk_lo", 1, g[1].sclk, 0);
        check("div2_sclk_lo", 0, g[0].sclk, 0);
        @(negedge clk);
        check("div2_sclk_hi", 0, g[0].sclk, 1);
        check("div2_shift", 0, g[0].shift_en, 1);
        wait_idle("frame1");
        @(negedge clk);
        check("pulses", 0, g[0].pulses - p0, 16);
        check("pulses", 1, g[1].pulses - p1, 8);
        check("frames", 0, g[0].fdone - f0, 1);
        check("frames", 1, g[1].fdone - f1, 1);
        check("nbytes", 0, g[0].nbytes - b0, 2);
        check("byte0", 0, g[0].got_b[b0 % 64], 8'hA5);
        check("last0", 0, g[0].got_l[b0 % 64], 0);
        check("byte1", 0, g[0].got_b[(b0 + 1) % 64], 8'h3C);
        check("last1", 0, g[0].got_l[(b0 + 1) % 64], 1);
        check("byte0", 1, g[1].got_b[b1 % 64], 8'hA5);
        check("last0", 1, g[1].got_l[b1 % 64], 1);

        // Consumer stalls after the first byte: second capture must wait.
        byte_ready = 0;
        pulse_start();
        n = 0;
        while (!g[0].byte_valid && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) timeout("first byte");
        repeat (45) @(negedge clk);
        check("stall_busy", 0, g[0].busy, 1);
        check("stall_sclk", 0, g[0].sclk, 0);
        check("stall_cs_n", 0, g[0].cs_n, 0);
        check("stall_data", 0, g[0].byte_data, 8'hA5);
        byte_ready = 1;
        @(negedge clk);
        check("reload_data", 0, g[0].byte_data, 8'h3C);
        check("reload_valid", 0, g[0].byte_valid, 1);
        check("reload_last", 0, g[0].byte_last, 1);
        wait_idle("stall frame");

        // Abort after three shift pulses; then a clean frame.
        f0 = g[0].fdone;
        p0 = g[0].pulses;
        pulse_start();
        n = 0;
        while ((g[0].pulses - p0) < 3 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) timeout("three pulses");
        abort = 1;
        @(negedge clk); abort = 0;
        check("abort_busy", 0, g[0].busy, 0);
        check("abort_cs_n", 0, g[0].cs_n, 1);
        check("abort_valid", 0, g[0].byte_valid, 0);
        wait_idle("abort");
        repeat (2) @(negedge clk);
        check("abort_no_done", 0, g[0].fdone - f0, 0);
        p0 = g[0].pulses;
        pulse_start();
        wait_idle("after abort");
        @(negedge clk);
        check("clean_pulses", 0, g[0].pulses - p0, 16);

        // Reset in the middle of a high half-period with a byte pending.
        byte_ready = 0;
        pulse_start();
        n = 0;
        while (!(g[0].byte_valid && g[0].sclk) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) timeout("pending byte");
        rst_n = 0; start = 1;
        @(negedge clk);
        check("mrst_busy", 0, g[0].busy, 0);
        check("mrst_cs_n", 0, g[0].cs_n, 1);
        check("mrst_valid", 0, g[0].byte_valid, 0);
        check("mrst_data", 0, g[0].byte_data, 8'h00);
        @(negedge clk);
        check("mrst_start_ignored", 0, g[0].busy, 0);
        rst_n = 1; start = 0; byte_ready = 1;
        @(negedge clk);

        // start held: back-to-back frames separated by one IDLE cycle.
        start = 1;
        n = 0;
        while (!g[1].frame_done && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) timeout("held start");
        @(negedge clk);
        check("gap_idle", 1, g[1].busy, 0);
        @(negedge clk);
        check("gap_restart", 1, g[1].busy, 1);
        start = 0;
        wait_idle("held start");

        // Randomised traffic checked by the per-cycle model.
        directed = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start      = ($urandom_range(0, 11) == 0);
            abort      = ($urandom_range(0, 149) == 0);
            byte_ready = ($urandom_range(0, 2) != 0);
            rst_n      = ($urandom_range(0, 999) != 0);
        end
        @(negedge clk);
        start = 0; abort = 0; rst_n = 1; byte_ready = 1;
        wait_idle("random");
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
